// File: rtl/mem_if_ctrl_if.sv
// ----------------------------------------------------------------------------
// mem_if_ctrl_if
// Bundles the control-unit handshake and the single-port RAM bus that
// mem_if_ctrl sits between.
//
// Signals
//   req        control unit -> ctrl   access request, held until ack
//   we         control unit -> ctrl   1 = word write, 0 = word read
//   addr[31:0] control unit -> ctrl   byte address
//   wdata[31:0]control unit -> ctrl   write data
//   busy       ctrl -> control unit   high whenever the FSM is not idle
//   ack        ctrl -> control unit   one-cycle completion pulse
//   err        ctrl -> control unit   rejected access, meaningful with ack
//   rdata[31:0]ctrl -> control unit   last successfully read word
//   ram_addr[9:0]  ctrl -> RAM        word address
//   ram_din[31:0]  ctrl -> RAM        write data
//   ram_we         ctrl -> RAM        write strobe
//   ram_regce      ctrl -> RAM        output register clock enable
//   ram_dout[31:0] RAM -> ctrl        RAM output register
//
// Modports
//   slave  : the controller (mem_if_ctrl)
//   master : its environment (control unit plus RAM)
// ----------------------------------------------------------------------------
interface mem_if_ctrl_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        ack;
    logic        err;
    logic [31:0] rdata;
    logic [9:0]  ram_addr;
    logic [31:0] ram_din;
    logic        ram_we;
    logic        ram_regce;
    logic [31:0] ram_dout;

    modport slave (
        input  req, we, addr, wdata, ram_dout,
        output busy, ack, err, rdata, ram_addr, ram_din, ram_we, ram_regce
    );

    modport master (
        output req, we, addr, wdata, ram_dout,
        input  busy, ack, err, rdata, ram_addr, ram_din, ram_we, ram_regce
    );
endinterface

// File: rtl/mem_if_ctrl.sv
// ----------------------------------------------------------------------------
// mem_if_ctrl
// Turns single-word read/write requests from a control unit into accesses
// on a 1024 x 32 single-port RAM with a two-stage read pipeline (address
// register, then an output register gated by ram_regce).
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset, aborts any access in progress
//   bus  : mem_if_ctrl_if.slave (handshake + RAM bus, see interface file)
//
// Timing, counted from the edge that accepts req (cycle 0):
//   rejected : RESP in cycle 1
//   write    : WRITE (ram_we) cycle 1, RESP cycle 2
//   read     : RADDR 1, RWAIT (ram_regce) 2, RCAP 3, RESP 4
// All handshake and RAM strobes are registered alongside the state.
// ----------------------------------------------------------------------------
module mem_if_ctrl (
    input  logic          clk,
    input  logic          rst,
    mem_if_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RADDR = 3'd1,
        RWAIT = 3'd2,
        RCAP  = 3'd3,
        WRITE = 3'd4,
        RESP  = 3'd5
    } state_t;

    state_t      state_q;
    logic [9:0]  word_addr_q;   // latched addr[11:2]
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        busy_q;
    logic        ack_q;
    logic        err_q;
    logic        ram_we_q;
    logic        ram_regce_q;

    // Only word-aligned addresses inside the 4 KB window reach the RAM.
    // Evaluated on the live request, which is exactly the value latched on
    // the accepting edge.
    logic access_ok_d;
    assign access_ok_d = (bus.addr[1:0] == 2'b00) && (bus.addr[31:12] == 20'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            word_addr_q <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            busy_q      <= 1'b0;
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_regce_q <= 1'b0;
        end else begin
            // Pulsed outputs default low; each state raises only its own.
            ack_q       <= 1'b0;
            err_q       <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_regce_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (bus.req) begin
                        word_addr_q <= bus.addr[11:2];
                        wdata_q     <= bus.wdata;
                        busy_q      <= 1'b1;
                        if (!access_ok_d) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (bus.we) begin
                            state_q  <= WRITE;
                            ram_we_q <= 1'b1;
                        end else begin
                            state_q <= RADDR;
                        end
                    end
                end
                RADDR: begin
                    // RAM captures ram_addr on this edge; its output
                    // register is enabled in the following cycle.
                    state_q     <= RWAIT;
                    ram_regce_q <= 1'b1;
                end
                RWAIT: begin
                    state_q <= RCAP;
                end
                RCAP: begin
                    rdata_q <= bus.ram_dout;
                    state_q <= RESP;
                    ack_q   <= 1'b1;
                end
                WRITE: begin
                    state_q <= RESP;
                    ack_q   <= 1'b1;
                end
                RESP: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.ack       = ack_q;
    assign bus.err       = err_q;
    assign bus.rdata     = rdata_q;
    assign bus.ram_addr  = word_addr_q;
    assign bus.ram_din   = wdata_q;
    assign bus.ram_we    = ram_we_q;
    assign bus.ram_regce = ram_regce_q;

endmodule

// File: tb/tb_mem_if_ctrl.sv
// ----------------------------------------------------------------------------
// tb_mem_if_ctrl
// Directed scenarios followed by random accesses. A behavioural RAM with a
// two-stage read pipeline sits on the RAM side; expectations come from a
// shadow word array and the access rules (alignment, 4 KB window, fixed
// latencies per access type).
// ----------------------------------------------------------------------------
module tb_mem_if_ctrl;

    logic clk = 1'b0;
    logic rst;
    logic ram_clr;

    always #5 clk = ~clk;

    mem_if_ctrl_if bus ();

    mem_if_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- RAM model: address reg, then regce-gated output reg
    logic [31:0] ram_mem [0:1023];
    logic [9:0]  ram_areg;
    logic [31:0] ram_oreg;

    always @(posedge clk) begin
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) ram_mem[i] <= '0;
            ram_areg <= '0;
            ram_oreg <= '0;
        end else begin
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_din;
            ram_areg <= bus.ram_addr;
            if (bus.ram_regce) ram_oreg <= ram_mem[ram_areg];
        end
    end

    assign bus.ram_dout = ram_oreg;

    // ---------------- reference model state
    logic [31:0] shadow [0:1023];
    logic [31:0] exp_rdata;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One complete access. poke_rwait changes the request inputs while the
    // access is in RWAIT to show that nothing is re-latched.
    task automatic do_access(input bit w, input logic [31:0] a, input logic [31:0] d,
                             input bit poke_rwait);
        bit          valid;
        int          ack_cyc, we_n, we_first, rg_n, rg_first;
        int          busy_bad, err_bad, addr_bad, exp_lat;
        logic [9:0]  addr0;
        logic [31:0] din0;
        logic        err_seen;
        logic [31:0] rd_seen;

        valid = (a[1:0] == 2'b00) && (a[31:12] == 20'd0);
        ack_cyc = 0; we_n = 0; we_first = 0; rg_n = 0; rg_first = 0;
        busy_bad = 0; err_bad = 0; addr_bad = 0;
        addr0 = '0; din0 = '0; err_seen = 1'b0; rd_seen = '0;

        @(negedge clk);
        bus.req = 1'b1; bus.we = w; bus.addr = a; bus.wdata = d;

        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.ram_we)    begin we_n++; if (we_first == 0) we_first = c; end
            if (bus.ram_regce) begin rg_n++; if (rg_first == 0) rg_first = c; end
            if (!bus.busy) busy_bad++;
            if (!bus.ack && bus.err) err_bad++;
            if (c == 1) begin
                addr0 = bus.ram_addr;
                din0  = bus.ram_din;
            end else if (bus.ram_addr !== addr0 || bus.ram_din !== din0) begin
                addr_bad++;
            end
            if (poke_rwait && c == 2) begin
                bus.addr = a ^ 32'h0000_0040; bus.wdata = ~d; bus.we = ~w;
            end
            if (bus.ack) begin
                ack_cyc  = c;
                err_seen = bus.err;
                rd_seen  = bus.rdata;
                bus.req  = 1'b0;
                break;
            end
        end

        exp_lat = !valid ? 1 : (w ? 2 : 4);
        if (valid && w)  shadow[a[11:2]] = d;
        if (valid && !w) exp_rdata = shadow[a[11:2]];

        check("ack_cycle",   32'(ack_cyc),  32'(exp_lat));
        check("err",         {31'd0, err_seen}, {31'd0, !valid});
        check("rdata",       rd_seen,       exp_rdata);
        check("ram_addr",    {22'd0, addr0}, {22'd0, a[11:2]});
        check("ram_din",     din0,          d);
        check("ram_we_cnt",  32'(we_n),     (valid && w) ? 32'd1 : 32'd0);
        check("ram_we_cyc",  32'(we_first), (valid && w) ? 32'd1 : 32'd0);
        check("regce_cnt",   32'(rg_n),     (valid && !w) ? 32'd1 : 32'd0);
        check("regce_cyc",   32'(rg_first), (valid && !w) ? 32'd2 : 32'd0);
        check("busy_low",    32'(busy_bad), 32'd0);
        check("err_no_ack",  32'(err_bad),  32'd0);
        check("bus_stable",  32'(addr_bad), 32'd0);

        // Idle cycle after RESP: no second ack, not busy.
        @(negedge clk);
        check("idle_ack",  {31'd0, bus.ack},  32'd0);
        check("idle_busy", {31'd0, bus.busy}, 32'd0);

        $display("txn we=%0d addr=%h wdata=%h ack_cyc=%0d err=%0d rdata=%h",
                 w, a, d, ack_cyc, err_seen, rd_seen);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, d, v;
        bit          w;
        int          ack_n, ack1, ack2, we_n;
        logic [31:0] rd2;
        logic        e1, e2;

        for (int i = 0; i < 1024; i++) shadow[i] = '0;
        exp_rdata = '0;
        rst = 1'b1; ram_clr = 1'b1;
        bus.req = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wdata = '0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_busy",   {31'd0, bus.busy},      32'd0);
        check("rst_ack",    {31'd0, bus.ack},       32'd0);
        check("rst_err",    {31'd0, bus.err},       32'd0);
        check("rst_we",     {31'd0, bus.ram_we},    32'd0);
        check("rst_regce",  {31'd0, bus.ram_regce}, 32'd0);
        check("rst_rdata",  bus.rdata,              32'd0);
        check("rst_raddr",  {22'd0, bus.ram_addr},  32'd0);
        check("rst_rdin",   bus.ram_din,            32'd0);
        rst = 1'b0; ram_clr = 1'b0;
        @(negedge clk);

        // Write then read
        do_access(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0);
        do_access(1'b0, 32'h0000_0010, 32'h0, 1'b0);
        // Misaligned read leaves rdata alone
        do_access(1'b0, 32'h0000_0006, 32'h0, 1'b0);
        // Boundaries
        do_access(1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 1'b0);
        do_access(1'b1, 32'h0000_1000, 32'h1111_2222, 1'b0);
        do_access(1'b0, 32'h0000_0FFC, 32'h0, 1'b0);
        do_access(1'b0, 32'h0000_0000, 32'h0, 1'b0);
        // Request inputs disturbed during RWAIT
        do_access(1'b0, 32'h0000_0010, 32'h0, 1'b1);

        // Reset during RCAP of a read
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b0; bus.addr = 32'h0000_0FFC;
        ack_n = 0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            if (bus.ack) ack_n++;
        end
        rst = 1'b1; bus.req = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",  {31'd0, bus.busy}, 32'd0);
        check("mid_rst_ack",   {31'd0, bus.ack},  32'd0);
        check("mid_rst_rdata", bus.rdata,         32'd0);
        rst = 1'b0;
        exp_rdata = '0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ack) ack_n++;
        end
        check("mid_rst_noack", 32'(ack_n), 32'd0);
        $display("txn reset during read RCAP, acks=%0d rdata=%h", ack_n, bus.rdata);
        do_access(1'b0, 32'h0000_0010, 32'h0, 1'b0);

        // Write request coinciding with reset never reaches the RAM
        @(negedge clk);
        rst = 1'b1; bus.req = 1'b1; bus.we = 1'b1;
        bus.addr = 32'h0000_0020; bus.wdata = 32'h1234_5678;
        @(negedge clk);
        rst = 1'b0; bus.req = 1'b0;
        we_n = 0; ack_n = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ram_we) we_n++;
            if (bus.ack) ack_n++;
        end
        check("rst_wr_we",  32'(we_n),  32'd0);
        check("rst_wr_ack", 32'(ack_n), 32'd0);
        $display("txn write under reset, ram_we=%0d acks=%0d", we_n, ack_n);
        exp_rdata = '0;
        do_access(1'b0, 32'h0000_0020, 32'h0, 1'b0);

        // Back-to-back with req held: write then read of the same word
        v = 32'hA5A5_0F0F;
        @(negedge clk);
        bus.req = 1'b1; bus.we = 1'b1; bus.addr = 32'h0000_0030; bus.wdata = v;
        ack1 = 0; ack2 = 0; e1 = 1'b0; e2 = 1'b0; rd2 = '0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (bus.ack && ack1 == 0) begin
                ack1 = c; e1 = bus.err; bus.we = 1'b0;
            end else if (bus.ack) begin
                ack2 = c; e2 = bus.err; rd2 = bus.rdata; bus.req = 1'b0;
                break;
            end
        end
        shadow[12] = v;
        exp_rdata  = v;
        check("b2b_ack_wr", 32'(ack1), 32'd2);
        check("b2b_ack_rd", 32'(ack2), 32'd7);
        check("b2b_err",    {30'd0, e1, e2}, 32'd0);
        check("b2b_rdata",  rd2, exp_rdata);
        $display("txn back-to-back wr/rd addr=00000030 acks=%0d,%0d rdata=%h", ack1, ack2, rd2);
        @(negedge clk);

        // Random accesses
        for (int n = 0; n < 60; n++) begin
            int kind;
            kind = $urandom_range(0, 9);
            w    = 1'($urandom_range(0, 1));
            d    = $urandom;
            a    = {20'd0, 6'($urandom_range(0, 15)), 6'd0} | 32'($urandom_range(0, 3) << 2);
            if (kind == 0)      a = a | 32'($urandom_range(1, 3));
            else if (kind == 1) a = a | {20'($urandom_range(1, 32'hF_FFFF)), 12'd0};
            else if (kind == 2) a = 32'h0000_0FFC;
            do_access(w, a, d, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
